// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: ALU op codes, branch funct3 codes,
// serial shifter states and small helpers used by the EX stage and its shifter.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_SLT   = 4'h8,
    ALU_SLTU  = 4'h9,
    ALU_PASSB = 4'hA
  } alu_op_e;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic {
    SH_IDLE  = 1'b0,
    SH_SHIFT = 1'b1
  } sh_state_e;

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic lt_s;
    logic lt_u;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    case (f3)
      BR_EQ:   br_taken = (a == b);
      BR_NE:   br_taken = (a != b);
      BR_LT:   br_taken = lt_s;
      BR_GE:   br_taken = !lt_s;
      BR_LTU:  br_taken = lt_u;
      BR_GEU:  br_taken = !lt_u;
      default: br_taken = 1'b0;
    endcase
  endfunction

  // One-bit step of the serial shifter; anything not SLL/SRA is treated as SRL.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op,
                                                 input logic [XLEN-1:0] v);
    case (op)
      ALU_SLL: shift_one = {v[XLEN-2:0], 1'b0};
      ALU_SRA: shift_one = {v[XLEN-1], v[XLEN-1:1]};
      default: shift_one = {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA. o_done pulses in the final
// SHIFT cycle while o_result holds the fully shifted value.
//   state    | meaning
//   SH_IDLE  | waiting for i_start (amount must be non-zero)
//   SH_SHIFT | shifting one bit per cycle, r_cnt bits still to go
module serial_shifter
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [4:0]      i_amount,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_operand,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  sh_state_e       r_state;
  sh_state_e       w_state_nxt;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_val;
  logic [3:0]      r_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SH_IDLE;
      r_cnt   <= 5'd0;
      r_val   <= '0;
      r_op    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start && (r_state == SH_IDLE)) begin
        r_cnt <= i_amount;
        r_val <= i_operand;
        r_op  <= i_op;
      end else if (r_state == SH_SHIFT) begin
        r_cnt <= r_cnt - 5'd1;
        r_val <= shift_one(r_op, r_val);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_idle      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_result    = shift_one(r_op, r_val);
    case (r_state)
      SH_IDLE: begin
        o_idle = 1'b1;
        if (i_start) w_state_nxt = SH_SHIFT;
      end
      SH_SHIFT: begin
        o_busy = (r_cnt > 5'd1);
        if (r_cnt == 5'd1) begin
          o_done      = 1'b1;
          w_state_nxt = SH_IDLE;
        end
      end
      default: w_state_nxt = SH_IDLE;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution with redirect,
// optional serial shifter, and the registered EX/MEM boundary.
module ex_stage
  import riscv_pkg::*;
#(
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] data_1_in,
  input  logic [XLEN-1:0] data_2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [3:0]      alu_ctrl_in,
  input  logic            alu_src_in,
  input  logic            auipc_in,
  input  logic            pc_src_in,
  input  logic            branch_in,
  input  logic            jump_in,
  input  logic            mem_wen_in,
  input  logic            wb_sel_in,
  input  logic            reg_wb_in,
  input  logic            nop_in,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [4:0]      fwd_mem_rd,
  input  logic            fwd_mem_wen,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic [4:0]      fwd_wb_rd,
  input  logic            fwd_wb_wen,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic            mem_wen_out,
  output logic            wb_sel_out,
  output logic            reg_wb_out,
  output logic            nop_out,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_busy
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_jump_tgt;
  logic [4:0]      w_shamt;
  logic            w_is_shift;
  logic            w_taken;
  logic            w_start;
  logic            w_sh_idle;
  logic            w_sh_busy;
  logic            w_sh_done;
  logic [XLEN-1:0] w_sh_result;

  logic [4:0]      r_sh_rd;
  logic            r_sh_reg_wb;
  logic            r_sh_wb_sel;
  logic            r_sh_mem_wen;
  logic [XLEN-1:0] r_sh_store;

  // EX/MEM hit takes priority: it holds the younger producer.
  always_comb begin
    if (fwd_mem_wen && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == rs1_in))
      w_fwd_a = fwd_mem_data;
    else if (fwd_wb_wen && (fwd_wb_rd != 5'd0) && (fwd_wb_rd == rs1_in))
      w_fwd_a = fwd_wb_data;
    else
      w_fwd_a = data_1_in;

    if (fwd_mem_wen && (fwd_mem_rd != 5'd0) && (fwd_mem_rd == rs2_in))
      w_fwd_b = fwd_mem_data;
    else if (fwd_wb_wen && (fwd_wb_rd != 5'd0) && (fwd_wb_rd == rs2_in))
      w_fwd_b = fwd_wb_data;
    else
      w_fwd_b = data_2_in;
  end

  assign w_op_a  = auipc_in ? pc_in : w_fwd_a;
  assign w_op_b  = alu_src_in ? imm_in : w_fwd_b;
  assign w_shamt = w_op_b[4:0];

  // Branches reuse alu_ctrl_in for funct3, so they must never look like a shift.
  assign w_is_shift = !branch_in && !jump_in &&
                      ((alu_ctrl_in == ALU_SLL) || (alu_ctrl_in == ALU_SRL) ||
                       (alu_ctrl_in == ALU_SRA));
  assign w_start    = SERIAL_SHIFT && w_sh_idle && !nop_in && w_is_shift &&
                      (w_shamt != 5'd0);

  // With the serial shifter present, only zero-amount shifts reach the ALU.
  always_comb begin
    w_alu = '0;
    case (alu_ctrl_in)
      ALU_ADD:   w_alu = w_op_a + w_op_b;
      ALU_SUB:   w_alu = w_op_a - w_op_b;
      ALU_AND:   w_alu = w_op_a & w_op_b;
      ALU_OR:    w_alu = w_op_a | w_op_b;
      ALU_XOR:   w_alu = w_op_a ^ w_op_b;
      ALU_SLL:   w_alu = SERIAL_SHIFT ? w_op_a : (w_op_a << w_shamt);
      ALU_SRL:   w_alu = SERIAL_SHIFT ? w_op_a : (w_op_a >> w_shamt);
      ALU_SRA:   w_alu = SERIAL_SHIFT ? w_op_a : $unsigned($signed(w_op_a) >>> w_shamt);
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
      ALU_PASSB: w_alu = w_op_b;
      default:   w_alu = '0;
    endcase
  end

  assign w_taken        = branch_in && br_taken(alu_ctrl_in[2:0], w_fwd_a, w_fwd_b);
  assign w_jump_tgt     = (pc_src_in ? pc_in : w_fwd_a) + imm_in;
  assign redirect_valid = !nop_in && w_sh_idle && (jump_in || w_taken);
  assign redirect_pc    = jump_in ? {w_jump_tgt[XLEN-1:1], 1'b0} : (pc_in + imm_in);
  assign ex_busy        = w_start || w_sh_busy;

  generate
    if (SERIAL_SHIFT) begin : g_serial
      serial_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_amount  (w_shamt),
        .i_op      (alu_ctrl_in),
        .i_operand (w_op_a),
        .o_idle    (w_sh_idle),
        .o_busy    (w_sh_busy),
        .o_done    (w_sh_done),
        .o_result  (w_sh_result)
      );
    end else begin : g_barrel
      assign w_sh_idle   = 1'b1;
      assign w_sh_busy   = 1'b0;
      assign w_sh_done   = 1'b0;
      assign w_sh_result = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_rd      <= 5'd0;
      r_sh_reg_wb  <= 1'b0;
      r_sh_wb_sel  <= 1'b0;
      r_sh_mem_wen <= 1'b0;
      r_sh_store   <= '0;
    end else if (w_start) begin
      r_sh_rd      <= rd_in;
      r_sh_reg_wb  <= reg_wb_in;
      r_sh_wb_sel  <= wb_sel_in;
      r_sh_mem_wen <= mem_wen_in;
      r_sh_store   <= w_fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= 5'd0;
      mem_wen_out    <= 1'b0;
      wb_sel_out     <= 1'b0;
      reg_wb_out     <= 1'b0;
      nop_out        <= 1'b1;
    end else if (w_sh_done) begin
      alu_result_out <= w_sh_result;
      store_data_out <= r_sh_store;
      rd_out         <= r_sh_rd;
      mem_wen_out    <= r_sh_mem_wen;
      wb_sel_out     <= r_sh_wb_sel;
      reg_wb_out     <= r_sh_reg_wb;
      nop_out        <= 1'b0;
    end else if (nop_in || w_start || !w_sh_idle) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= 5'd0;
      mem_wen_out    <= 1'b0;
      wb_sel_out     <= 1'b0;
      reg_wb_out     <= 1'b0;
      nop_out        <= 1'b1;
    end else begin
      alu_result_out <= jump_in ? (pc_in + 32'd4) : w_alu;
      store_data_out <= w_fwd_b;
      rd_out         <= rd_in;
      mem_wen_out    <= mem_wen_in;
      wb_sel_out     <= wb_sel_in;
      reg_wb_out     <= reg_wb_in;
      nop_out        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, randomized single-cycle ops against
// a behavioural model, and hand sequences for serial shifts and reset mid-shift.
module tb_ex_stage;

  typedef struct {
    logic [31:0] d1, d2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        alu_src, auipc, pc_src, branch, jump, mem_wen, wb_sel, reg_wb, nop;
    logic [31:0] mdata;
    logic [4:0]  mrd;
    logic        mwen;
    logic [31:0] wdata;
    logic [4:0]  wrd;
    logic        wwen;
  } in_t;

  typedef struct {
    logic [31:0] res, store, rpc;
    logic [4:0]  rd;
    logic        mw, ws, rw, nop, rv, chk_res;
  } exp_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [31:0] res;
    logic        chk_res;
    logic        rv;
    logic [31:0] rpc;
  } tv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_1_in, data_2_in, imm_in, pc_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [3:0]  alu_ctrl_in;
  logic        alu_src_in, auipc_in, pc_src_in, branch_in, jump_in;
  logic        mem_wen_in, wb_sel_in, reg_wb_in, nop_in;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic        fwd_mem_wen, fwd_wb_wen;
  logic [31:0] alu_result_out, store_data_out, redirect_pc;
  logic [4:0]  rd_out;
  logic        mem_wen_out, wb_sel_out, reg_wb_out, nop_out, redirect_valid, ex_busy;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.SERIAL_SHIFT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .data_1_in(data_1_in), .data_2_in(data_2_in), .imm_in(imm_in), .pc_in(pc_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .alu_ctrl_in(alu_ctrl_in),
    .alu_src_in(alu_src_in), .auipc_in(auipc_in), .pc_src_in(pc_src_in),
    .branch_in(branch_in), .jump_in(jump_in), .mem_wen_in(mem_wen_in),
    .wb_sel_in(wb_sel_in), .reg_wb_in(reg_wb_in), .nop_in(nop_in),
    .fwd_mem_data(fwd_mem_data), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_wen(fwd_mem_wen),
    .fwd_wb_data(fwd_wb_data), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_wen(fwd_wb_wen),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .mem_wen_out(mem_wen_out), .wb_sel_out(wb_sel_out), .reg_wb_out(reg_wb_out),
    .nop_out(nop_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t mk_bubble();
    in_t v;
    v = '{default: '0};
    v.nop = 1'b1;
    return v;
  endfunction

  function automatic in_t mk(input logic [3:0] ctrl, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] imm,
                             input logic alu_src);
    in_t v;
    v = '{default: '0};
    v.ctrl = ctrl; v.d1 = d1; v.d2 = d2; v.imm = imm; v.alu_src = alu_src;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd9; v.reg_wb = 1'b1;
    return v;
  endfunction

  task automatic apply(input in_t v);
    data_1_in = v.d1;  data_2_in = v.d2;  imm_in = v.imm;  pc_in = v.pc;
    rs1_in = v.rs1;    rs2_in = v.rs2;    rd_in = v.rd;    alu_ctrl_in = v.ctrl;
    alu_src_in = v.alu_src; auipc_in = v.auipc; pc_src_in = v.pc_src;
    branch_in = v.branch;   jump_in = v.jump;   mem_wen_in = v.mem_wen;
    wb_sel_in = v.wb_sel;   reg_wb_in = v.reg_wb; nop_in = v.nop;
    fwd_mem_data = v.mdata; fwd_mem_rd = v.mrd; fwd_mem_wen = v.mwen;
    fwd_wb_data = v.wdata;  fwd_wb_rd = v.wrd;  fwd_wb_wen = v.wwen;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] idex, input in_t v);
    if (v.mwen && v.mrd != 0 && v.mrd == rs) return v.mdata;
    if (v.wwen && v.wrd != 0 && v.wrd == rs) return v.wdata;
    return idex;
  endfunction

  function automatic logic [31:0] sh_ref(input int op, input logic [31:0] a, input int n);
    logic [31:0] pw;
    pw = 32'd1 << n;
    case (op)
      5:       return a * pw;
      6:       return a / pw;
      default: return $unsigned($signed(a) >>> n);
    endcase
  endfunction

  function automatic exp_t model(input in_t v);
    exp_t e;
    logic [31:0] fa, fb, a, b, r;
    longint sa, sb, ua, ub, sfa, sfb, ufa, ufb;
    logic taken;
    fa = fwd(v.rs1, v.d1, v);
    fb = fwd(v.rs2, v.d2, v);
    a = v.auipc ? v.pc : fa;
    b = v.alu_src ? v.imm : fb;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    sfa = longint'($signed(fa)); sfb = longint'($signed(fb));
    ufa = longint'(fa);          ufb = longint'(fb);
    case (v.ctrl)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5, 4'd6, 4'd7: r = sh_ref(int'(v.ctrl), a, int'(b[4:0]));
      4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    case (v.ctrl[2:0])
      3'd0:    taken = (fa == fb);
      3'd1:    taken = (fa != fb);
      3'd4:    taken = (sfa < sfb);
      3'd5:    taken = (sfa >= sfb);
      3'd6:    taken = (ufa < ufb);
      3'd7:    taken = (ufa >= ufb);
      default: taken = 1'b0;
    endcase
    e.rv  = !v.nop && (v.jump || (v.branch && taken));
    e.rpc = v.jump ? (((v.pc_src ? v.pc : fa) + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    if (v.nop) begin
      e.res = 0; e.store = 0; e.rd = 0; e.mw = 0; e.ws = 0; e.rw = 0; e.nop = 1;
      e.chk_res = 1;
    end else begin
      e.res = v.jump ? v.pc + 32'd4 : r;
      e.store = fb; e.rd = v.rd; e.mw = v.mem_wen; e.ws = v.wb_sel; e.rw = v.reg_wb;
      e.nop = 0; e.chk_res = !v.branch;
    end
    return e;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    int kind;
    logic [3:0] ops[8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};
    v = mk(4'd0, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
    v.rd = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) v.d2 = v.d1;
    v.pc = $urandom & 32'hFFFF_FFFC;
    v.auipc = ($urandom_range(0, 7) == 0);
    v.mem_wen = 1'($urandom_range(0, 1)); v.wb_sel = 1'($urandom_range(0, 1));
    v.reg_wb = 1'($urandom_range(0, 1));
    v.mdata = $urandom; v.mrd = 5'($urandom_range(0, 3)); v.mwen = 1'($urandom_range(0, 1));
    v.wdata = $urandom; v.wrd = 5'($urandom_range(0, 3)); v.wwen = 1'($urandom_range(0, 1));
    kind = $urandom_range(0, 11);
    if (kind < 2) begin
      v.branch = 1'b1; v.ctrl = 4'($urandom_range(0, 7));
    end else if (kind == 2) begin
      v.jump = 1'b1; v.pc_src = 1'($urandom_range(0, 1));
    end else if (kind == 3) begin
      v.ctrl = 4'($urandom_range(5, 7)); v.alu_src = 1'b1; v.imm[4:0] = 5'd0;
    end else if (kind == 4) begin
      v.ctrl = 4'($urandom_range(11, 15));
    end else begin
      v.ctrl = ops[$urandom_range(0, 7)];
    end
    v.nop = ($urandom_range(0, 7) == 0);
    return v;
  endfunction

  task automatic step_model(input in_t v);
    exp_t e;
    e = model(v);
    apply(v);
    #2;
    chk("rnd_redirect_valid", 32'(redirect_valid), 32'(e.rv));
    if (e.rv) chk("rnd_redirect_pc", redirect_pc, e.rpc);
    chk("rnd_busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    if (e.chk_res) chk("rnd_result", alu_result_out, e.res);
    chk("rnd_store", store_data_out, e.store);
    chk("rnd_rd", 32'(rd_out), 32'(e.rd));
    chk("rnd_ctl", {29'd0, mem_wen_out, wb_sel_out, reg_wb_out}, {29'd0, e.mw, e.ws, e.rw});
    chk("rnd_nop", 32'(nop_out), 32'(e.nop));
  endtask

  task automatic run_shift(input int op, input logic [31:0] a, input int n,
                           input logic [31:0] exp_res);
    in_t v;
    int busy_cyc, bubbles;
    logic done;
    v = mk(4'(op), a, 32'd0, 32'(n), 1'b1);
    v.rd = 5'd7;
    apply(v);
    #2;
    busy_cyc = ex_busy ? 1 : 0;
    @(posedge clk); #1;
    bubbles = nop_out ? 1 : 0;
    done = 1'b0;
    apply(mk_bubble());
    for (int k = 0; k < 40 && !done; k++) begin
      #2;
      if (ex_busy) busy_cyc++;
      chk("shift_no_redirect", 32'(redirect_valid), 32'd0);
      @(posedge clk); #1;
      if (nop_out) bubbles++;
      else done = 1'b1;
    end
    chk("shift_completed", 32'(done), 32'd1);
    chk("shift_busy_cycles", busy_cyc, n);
    chk("shift_bubbles", bubbles, n);
    chk("shift_result", alu_result_out, exp_res);
    chk("shift_rd", 32'(rd_out), 32'd7);
    chk("shift_reg_wb", 32'(reg_wb_out), 32'd1);
  endtask

  tv_t tv[15];

  initial begin
    int nres;
    in_t v;
    for (int i = 0; i < 15; i++) begin
      tv[i].name = "vec"; tv[i].chk_res = 1'b1; tv[i].rv = 1'b0; tv[i].rpc = 32'd0;
    end
    v = mk(4'd0, 32'd0, 32'd0, 32'd5, 1'b1);
    v.rs1 = 5'd3; v.mrd = 5'd3; v.mdata = 32'd10; v.mwen = 1'b1;
    v.wrd = 5'd3; v.wdata = 32'd20; v.wwen = 1'b1;
    tv[0].name = "add_mem_wins"; tv[0].in = v; tv[0].res = 32'd15;
    v = mk(4'd0, 32'h11, 32'd0, 32'd0, 1'b1);
    v.rs1 = 5'd0; v.mrd = 5'd0; v.mdata = 32'd99; v.mwen = 1'b1;
    tv[1].name = "x0_no_fwd"; tv[1].in = v; tv[1].res = 32'h11;
    v = mk(4'd0, 32'd7, 32'd7, 32'h20, 1'b0);
    v.pc = 32'h100; v.branch = 1'b1; v.reg_wb = 1'b0;
    tv[2].name = "beq_taken"; tv[2].in = v; tv[2].chk_res = 1'b0; tv[2].rv = 1'b1; tv[2].rpc = 32'h120;
    v.ctrl = 4'd6; v.d1 = 32'hFFFF_FFFF; v.d2 = 32'd1;
    tv[3].name = "bltu_not_taken"; tv[3].in = v; tv[3].chk_res = 1'b0;
    v.ctrl = 4'd4;
    tv[4].name = "blt_taken"; tv[4].in = v; tv[4].chk_res = 1'b0; tv[4].rv = 1'b1; tv[4].rpc = 32'h120;
    v = mk(4'd0, 32'h1001, 32'd0, 32'd2, 1'b1);
    v.pc = 32'h40; v.jump = 1'b1; v.pc_src = 1'b0;
    tv[5].name = "jalr"; tv[5].in = v; tv[5].res = 32'h44; tv[5].rv = 1'b1; tv[5].rpc = 32'h1002;
    tv[6].name = "sra_by_0"; tv[6].in = mk(4'd7, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
    tv[6].res = 32'h8000_0000;
    tv[7].name = "sub_wrap"; tv[7].in = mk(4'd1, 32'd5, 32'd7, 32'd0, 1'b0); tv[7].res = 32'hFFFF_FFFE;
    tv[8].name = "passb"; tv[8].in = mk(4'd10, 32'h1234, 32'd0, 32'hABCD_E000, 1'b1);
    tv[8].res = 32'hABCD_E000;
    tv[9].name = "op_b_zero"; tv[9].in = mk(4'd11, 32'd5, 32'd6, 32'd0, 1'b0); tv[9].res = 32'd0;
    tv[10].name = "slt"; tv[10].in = mk(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); tv[10].res = 32'd1;
    tv[11].name = "sltu"; tv[11].in = mk(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0); tv[11].res = 32'd0;
    v = mk(4'd0, 32'd0, 32'd0, 32'h1000, 1'b1);
    v.auipc = 1'b1; v.pc = 32'h200;
    tv[12].name = "auipc"; tv[12].in = v; tv[12].res = 32'h1200;
    v = mk(4'd3, 32'hF0, 32'd0, 32'd0, 1'b0);
    v.rs2 = 5'd4; v.wrd = 5'd4; v.wwen = 1'b1; v.wdata = 32'h0F; v.mrd = 5'd5; v.mwen = 1'b1;
    tv[13].name = "or_wb_fwd_rs2"; tv[13].in = v; tv[13].res = 32'hFF;
    v = mk(4'd0, 32'd0, 32'd0, 32'h11, 1'b1);
    v.pc = 32'h80; v.jump = 1'b1; v.pc_src = 1'b1;
    tv[14].name = "jal"; tv[14].in = v; tv[14].res = 32'h84; tv[14].rv = 1'b1; tv[14].rpc = 32'h90;

    reset = 1'b1;
    apply(mk(4'd0, 32'd1, 32'd2, 32'd3, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_nop_out", 32'(nop_out), 32'd1);
    chk("reset_result", alu_result_out, 32'd0);
    chk("reset_rd", 32'(rd_out), 32'd0);
    chk("reset_reg_wb", 32'(reg_wb_out), 32'd0);
    chk("reset_busy", 32'(ex_busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply(tv[i].in);
      #2;
      chk({tv[i].name, "_redirect_valid"}, 32'(redirect_valid), 32'(tv[i].rv));
      if (tv[i].rv) chk({tv[i].name, "_redirect_pc"}, redirect_pc, tv[i].rpc);
      chk({tv[i].name, "_busy"}, 32'(ex_busy), 32'd0);
      @(posedge clk); #1;
      if (tv[i].chk_res) chk({tv[i].name, "_result"}, alu_result_out, tv[i].res);
      chk({tv[i].name, "_nop_out"}, 32'(nop_out), 32'd0);
      chk({tv[i].name, "_reg_wb"}, 32'(reg_wb_out), 32'(tv[i].in.reg_wb));
    end

    run_shift(5, 32'h1, 5, 32'h20);
    run_shift(7, 32'h8000_0000, 4, 32'hF800_0000);
    for (int i = 0; i < 6; i++) begin
      int op, n;
      logic [31:0] a;
      op = $urandom_range(5, 7); n = $urandom_range(1, 31); a = $urandom;
      run_shift(op, a, n, sh_ref(op, a, n));
    end

    for (int i = 0; i < 250; i++) step_model(rand_in());

    // SRL by 8, reset lands in the third cycle of the operation
    apply(mk(4'd6, 32'hFFFF_0000, 32'd0, 32'd8, 1'b1));
    #2;
    chk("rst_shift_start_busy", 32'(ex_busy), 32'd1);
    @(posedge clk); #1;
    apply(mk_bubble());
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_shift_busy", 32'(ex_busy), 32'd0);
    chk("rst_shift_nop_out", 32'(nop_out), 32'd1);
    chk("rst_shift_result", alu_result_out, 32'd0);
    v = mk(4'd0, 32'd100, 32'd23, 32'd0, 1'b0);
    apply(v);
    #2;
    chk("post_rst_add_busy", 32'(ex_busy), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_add_result", alu_result_out, 32'd123);
    chk("post_rst_add_nop", 32'(nop_out), 32'd0);
    apply(mk_bubble());
    nres = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!nop_out) nres++;
    end
    chk("post_rst_no_stale_result", nres, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
